// File: rtl/mipmap_optimized_ram.sv
// Two-port word RAM with per-lane write mask and 1-cycle registered reads.
// Optional mip-aware layout stores upper half of address space in a quarter bank.
module mipmap_optimized_ram #(
  parameter int    ADDR_WIDTH              = 14,
  parameter int    MEM_WIDTH               = 16,
  parameter int    WRITE_STROBE_WIDTH      = 16,
  parameter string MEMORY_PRIMITIVE        = "block",
  parameter int    ENABLE_LOD_OPTIMIZATION = 1
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic                                        write,
  input  logic [ADDR_WIDTH-1:0]                       writeAddr,
  input  logic [MEM_WIDTH-1:0]                        writeData,
  input  logic [MEM_WIDTH/WRITE_STROBE_WIDTH-1:0]     writeMask,
  output logic [MEM_WIDTH-1:0]                        writeDataOut,
  input  logic [ADDR_WIDTH-1:0]                       readAddr,
  output logic [MEM_WIDTH-1:0]                        readData
);

  localparam int LANES = MEM_WIDTH / WRITE_STROBE_WIDTH;
  localparam int SW    = WRITE_STROBE_WIDTH;

  // Elaboration-time sanity of the lane split and storage hint
  if ((MEM_WIDTH % WRITE_STROBE_WIDTH) != 0 || MEMORY_PRIMITIVE == "") begin : g_bad
    $error("mipmap_optimized_ram: bad MEM_WIDTH/WRITE_STROBE_WIDTH or empty hint");
  end

  if (ENABLE_LOD_OPTIMIZATION != 0) begin : g_lod
    localparam int MAIN_DEPTH = 1 << (ADDR_WIDTH - 1);
    localparam int MIP_DEPTH  = 1 << (ADDR_WIDTH - 2);

    logic [MEM_WIDTH-1:0] main_mem [MAIN_DEPTH];
    logic [MEM_WIDTH-1:0] mip_mem  [MIP_DEPTH];

    logic                  a_msb, b_msb;
    logic [ADDR_WIDTH-2:0] a_main_idx, b_main_idx;
    logic [ADDR_WIDTH-3:0] a_mip_idx, b_mip_idx;

    logic [MEM_WIDTH-1:0]  a_main_d, a_main_q, a_mip_d, a_mip_q;
    logic [MEM_WIDTH-1:0]  b_main_d, b_main_q, b_mip_d, b_mip_q;
    logic                  a_sel_d, a_sel_q, b_sel_d, b_sel_q;

    // Address split and read-first fetch from both banks
    always_comb begin
      a_msb      = writeAddr[ADDR_WIDTH-1];
      b_msb      = readAddr[ADDR_WIDTH-1];
      a_main_idx = writeAddr[ADDR_WIDTH-2:0];
      b_main_idx = readAddr[ADDR_WIDTH-2:0];
      a_mip_idx  = writeAddr[ADDR_WIDTH-3:0];
      b_mip_idx  = readAddr[ADDR_WIDTH-3:0];
      a_main_d   = main_mem[a_main_idx];
      a_mip_d    = mip_mem[a_mip_idx];
      b_main_d   = main_mem[b_main_idx];
      b_mip_d    = mip_mem[b_mip_idx];
      a_sel_d    = a_msb;
      b_sel_d    = b_msb;
    end

    // Masked write into the selected bank only; contents survive reset
    always_ff @(posedge clk) begin
      if (resetn && write) begin
        for (int i = 0; i < LANES; i++) begin
          if (writeMask[i]) begin
            if (a_msb) mip_mem[a_mip_idx][i*SW +: SW] <= writeData[i*SW +: SW];
            else       main_mem[a_main_idx][i*SW +: SW] <= writeData[i*SW +: SW];
          end
        end
      end
    end

    // Registered bank outputs with their bank-select bits
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        a_main_q <= '0;
        a_mip_q  <= '0;
        b_main_q <= '0;
        b_mip_q  <= '0;
        a_sel_q  <= 1'b0;
        b_sel_q  <= 1'b0;
      end else begin
        a_main_q <= a_main_d;
        a_mip_q  <= a_mip_d;
        b_main_q <= b_main_d;
        b_mip_q  <= b_mip_d;
        a_sel_q  <= a_sel_d;
        b_sel_q  <= b_sel_d;
      end
    end

    assign writeDataOut = a_sel_q ? a_mip_q : a_main_q;
    assign readData     = b_sel_q ? b_mip_q : b_main_q;

  end else begin : g_full
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [MEM_WIDTH-1:0] mem [DEPTH];
    logic [MEM_WIDTH-1:0] a_rd_d, a_rd_q, b_rd_d, b_rd_q;

    // Read-first fetch for both ports
    always_comb begin
      a_rd_d = mem[writeAddr];
      b_rd_d = mem[readAddr];
    end

    // Masked write; contents survive reset
    always_ff @(posedge clk) begin
      if (resetn && write) begin
        for (int i = 0; i < LANES; i++) begin
          if (writeMask[i]) mem[writeAddr][i*SW +: SW] <= writeData[i*SW +: SW];
        end
      end
    end

    // Registered read data for both ports
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        a_rd_q <= '0;
        b_rd_q <= '0;
      end else begin
        a_rd_q <= a_rd_d;
        b_rd_q <= b_rd_d;
      end
    end

    assign writeDataOut = a_rd_q;
    assign readData     = b_rd_q;
  end

endmodule

// File: tb/tb_mipmap_optimized_ram.sv
// Scoreboard bench for mipmap_optimized_ram.
// Drives a LOD and a full-decode instance with identical stimulus.
module tb_mipmap_optimized_ram;

  localparam int AW = 14;
  localparam int MW = 32;
  localparam int SW = 16;

  typedef struct {
    logic [MW-1:0] exp;
    string         nm;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          write = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [MW-1:0] wdata = '0;
  logic [1:0]    wmask = '0;
  logic [AW-1:0] raddr = '0;
  logic [MW-1:0] a_out0, b_out0, a_out1, b_out1;

  // bit0 = LOD instance, bit1 = full-decode instance
  logic [1:0] a_chk = '0, b_chk = '0;
  logic [1:0] a_pend = '0, b_pend = '0;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mipmap_optimized_ram #(
    .ADDR_WIDTH(AW), .MEM_WIDTH(MW), .WRITE_STROBE_WIDTH(SW),
    .MEMORY_PRIMITIVE("block"), .ENABLE_LOD_OPTIMIZATION(1)
  ) u_lod (
    .clk(clk), .resetn(resetn), .write(write),
    .writeAddr(waddr), .writeData(wdata), .writeMask(wmask),
    .writeDataOut(a_out0), .readAddr(raddr), .readData(b_out0)
  );

  mipmap_optimized_ram #(
    .ADDR_WIDTH(AW), .MEM_WIDTH(MW), .WRITE_STROBE_WIDTH(SW),
    .MEMORY_PRIMITIVE("block"), .ENABLE_LOD_OPTIMIZATION(0)
  ) u_full (
    .clk(clk), .resetn(resetn), .write(write),
    .writeAddr(waddr), .writeData(wdata), .writeMask(wmask),
    .writeDataOut(a_out1), .readAddr(raddr), .readData(b_out1)
  );

  task automatic cmp(input string nm, input logic [MW-1:0] got,
                     input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic pop_cmp(inout exp_t q[$], input string who,
                         input logic [MW-1:0] got);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_underflow: got %h expected none", who, got);
    end else begin
      e = q.pop_front();
      cmp({e.nm, "_", who}, got, e.exp);
    end
  endtask

  // Latch which checks were requested for this edge
  always @(posedge clk) begin
    a_pend <= a_chk;
    b_pend <= b_chk;
  end

  // Monitor: compare registered outputs half a cycle after the edge
  always @(negedge clk) begin
    if (a_pend[0]) pop_cmp(qa0, "a_lod", a_out0);
    if (a_pend[1]) pop_cmp(qa1, "a_full", a_out1);
    if (b_pend[0]) pop_cmp(qb0, "b_lod", b_out0);
    if (b_pend[1]) pop_cmp(qb1, "b_full", b_out1);
  end

  task automatic step(
    input logic we, input logic [AW-1:0] wa, input logic [MW-1:0] wd,
    input logic [1:0] wm, input logic [AW-1:0] ra,
    input logic [1:0] ca, input logic [MW-1:0] ea0, input logic [MW-1:0] ea1,
    input logic [1:0] cb, input logic [MW-1:0] eb0, input logic [MW-1:0] eb1,
    input string nm);
    write = we;
    waddr = wa;
    wdata = wd;
    wmask = wm;
    raddr = ra;
    a_chk = ca;
    b_chk = cb;
    if (ca[0]) qa0.push_back('{ea0, nm});
    if (ca[1]) qa1.push_back('{ea1, nm});
    if (cb[0]) qb0.push_back('{eb0, nm});
    if (cb[1]) qb1.push_back('{eb1, nm});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, waddr, '0, 2'b00, raddr, 2'b00, '0, '0, 2'b00, '0, '0, "idle");
  endtask

  initial begin
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("rst_a_lod", a_out0, '0);
    cmp("rst_b_lod", b_out0, '0);
    cmp("rst_a_full", a_out1, '0);
    cmp("rst_b_full", b_out1, '0);
    resetn = 1'b1;

    // Basic write then read on both ports
    step(1, 14'h0010, 32'h0000A5A5, 2'b11, 14'h0000, 0, '0, '0, 0, '0, '0, "w");
    step(0, 14'h0010, '0, 2'b00, 14'h0010,
         2'b11, 32'h0000A5A5, 32'h0000A5A5,
         2'b11, 32'h0000A5A5, 32'h0000A5A5, "basic");

    // Lane mask and port-A read-first
    step(1, 14'h0030, 32'h11112222, 2'b11, 14'h0000, 0, '0, '0, 0, '0, '0, "w");
    step(1, 14'h0030, 32'h3333FFFF, 2'b10, 14'h0000,
         2'b11, 32'h11112222, 32'h11112222, 0, '0, '0, "rdw_a");
    step(0, 14'h0030, '0, 2'b00, 14'h0000,
         2'b11, 32'h33332222, 32'h33332222, 0, '0, '0, "mask");

    // Port-B read-during-write returns old then new
    step(1, 14'h0020, 32'h00001234, 2'b11, 14'h0000, 0, '0, '0, 0, '0, '0, "w");
    step(1, 14'h0020, 32'h00005678, 2'b11, 14'h0020,
         2'b11, 32'h00001234, 32'h00001234,
         2'b11, 32'h00001234, 32'h00001234, "rdw_old");
    step(0, 14'h0020, '0, 2'b00, 14'h0020,
         2'b11, 32'h00005678, 32'h00005678,
         2'b11, 32'h00005678, 32'h00005678, "rdw_new");

    // Mip-bank aliasing versus full decoding
    step(1, 14'h2005, 32'h0000BEEF, 2'b11, 14'h0000, 0, '0, '0, 0, '0, '0, "w");
    step(0, 14'h2005, '0, 2'b00, 14'h3005,
         0, '0, '0, 2'b01, 32'h0000BEEF, '0, "alias");
    step(1, 14'h3005, 32'h0000D00D, 2'b11, 14'h2005,
         0, '0, '0, 2'b11, 32'h0000BEEF, 32'h0000BEEF, "alias_rdw");
    step(0, 14'h3005, '0, 2'b00, 14'h2005,
         2'b11, 32'h0000D00D, 32'h0000D00D,
         2'b11, 32'h0000D00D, 32'h0000BEEF, "alias_ovr");

    // Main-bank write does not disturb mip bank; bank select follows reads
    step(1, 14'h0005, 32'h0000CAFE, 2'b11, 14'h2005,
         0, '0, '0, 2'b11, 32'h0000D00D, 32'h0000BEEF, "bank_iso");
    step(0, 14'h0005, '0, 2'b00, 14'h0005,
         0, '0, '0, 2'b11, 32'h0000CAFE, 32'h0000CAFE, "main_rd");
    step(0, 14'h0005, '0, 2'b00, 14'h2005,
         2'b11, 32'h0000CAFE, 32'h0000CAFE,
         2'b11, 32'h0000D00D, 32'h0000BEEF, "mip_rd");
    step(0, 14'h2005, '0, 2'b00, 14'h0005,
         2'b11, 32'h0000D00D, 32'h0000BEEF,
         2'b11, 32'h0000CAFE, 32'h0000CAFE, "sel_sw");
    idle();

    // Mid-stream reset: outputs clear at once, writes ignored, data kept
    #2 resetn = 1'b0;
    #1;
    cmp("mid_rst_a_lod", a_out0, '0);
    cmp("mid_rst_b_lod", b_out0, '0);
    cmp("mid_rst_a_full", a_out1, '0);
    cmp("mid_rst_b_full", b_out1, '0);
    @(negedge clk);
    step(1, 14'h0010, 32'hFFFFFFFF, 2'b11, 14'h0000, 0, '0, '0, 0, '0, '0, "w");
    step(1, 14'h2005, 32'hFFFFFFFF, 2'b11, 14'h0000, 0, '0, '0, 0, '0, '0, "w");
    resetn = 1'b1;
    step(0, 14'h0030, '0, 2'b00, 14'h0010,
         2'b11, 32'h33332222, 32'h33332222,
         2'b11, 32'h0000A5A5, 32'h0000A5A5, "post_rst");
    step(0, 14'h2005, '0, 2'b00, 14'h3005,
         2'b11, 32'h0000D00D, 32'h0000BEEF,
         2'b11, 32'h0000D00D, 32'h0000D00D, "post_rst_mip");
    idle();

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10; i++) begin
      if (qa0.size() + qa1.size() + qb0.size() + qb1.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (qa0.size() + qa1.size() + qb0.size() + qb1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               qa0.size() + qa1.size() + qb0.size() + qb1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mipmap_optimized_ram.md
MIPMAP_OPTIMIZED_RAM -- requirements
Module: mipmap_optimized_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning word-address width of both ports.
REQ-002 SHALL have parameter MEM_WIDTH, default 16, meaning data word width in bits.
REQ-003 SHALL have parameter WRITE_STROBE_WIDTH, default 16, meaning bits per write-mask lane; MEM_WIDTH SHALL be an integer multiple of it.
REQ-004 SHALL have parameter MEMORY_PRIMITIVE, default "block", meaning a storage-inference hint only, with no functional effect.
REQ-005 SHALL have parameter ENABLE_LOD_OPTIMIZATION, default 1, meaning that reduced mipmap storage is enabled.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 write  input  1  write enable for port A.
REQ-009 writeAddr  input  ADDR_WIDTH  port A address, used for both write and read-back.
REQ-010 writeData  input  MEM_WIDTH  port A write data.
REQ-011 writeMask  input  MEM_WIDTH/WRITE_STROBE_WIDTH  per-lane write enable; bit i covers bits [i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH].
REQ-012 writeDataOut  output  MEM_WIDTH  port A registered read data.
REQ-013 readAddr  input  ADDR_WIDTH  port B read address.
REQ-014 readData  output  MEM_WIDTH  port B registered read data.

Function
REQ-015 Storage SHALL be a two-port RAM: port A read/write, port B read-only.
REQ-016 Port A write: on a clk edge with write=1, each lane with writeMask bit 1 SHALL be updated at writeAddr; lanes with mask 0 SHALL be unchanged.
REQ-017 Port A read: writeDataOut SHALL present the word at the writeAddr sampled on the previous edge, giving 1-cycle latency; it updates every cycle regardless of write.
REQ-018 Port B read: readData SHALL present the word at the readAddr sampled on the previous edge, giving 1-cycle latency, every cycle.
REQ-019 Read-during-write to the same address, on either port, SHALL return the old contents (read-first); the new data SHALL be visible from the next read onward.
REQ-020 With ENABLE_LOD_OPTIMIZATION=0, storage SHALL be a single bank of 2^ADDR_WIDTH words with full address decoding.
REQ-021 With ENABLE_LOD_OPTIMIZATION=1, storage SHALL be a main bank of 2^(ADDR_WIDTH-1) words plus a mip bank of 2^(ADDR_WIDTH-2) words (75% of full size).
REQ-022 In the optimized mode, an address with MSB=0 SHALL select the main bank, indexed by addr[ADDR_WIDTH-2:0].
REQ-023 In the optimized mode, an address with MSB=1 SHALL select the mip bank, indexed by addr[ADDR_WIDTH-3:0].
REQ-024 In the optimized mode, addr[ADDR_WIDTH-2] SHALL be ignored when MSB=1, so addresses 2^(AW-1)+k and 2^(AW-1)+2^(AW-2)+k alias the same word.
REQ-025 Bank-select for each port's output mux SHALL use that port's address MSB registered alongside the read, so the output matches the 1-cycle latency.
REQ-026 A write SHALL touch only the selected bank.
REQ-027 Both ports writing/reading different banks in the same cycle SHALL not interfere.
REQ-028 RAM contents SHALL be uninitialized after power-up and SHALL NOT be cleared by reset.

Reset
REQ-029 While resetn=0, readData and writeDataOut SHALL be 0 asynchronously.
REQ-030 Writes SHALL be ignored while resetn=0.
REQ-031 The first valid read data SHALL appear one edge after resetn deasserts.
REQ-032 Reset asserted mid-operation SHALL not corrupt stored words written before the reset assertion.

Verification
REQ-033 AW=14, MW=16: write 0xA5A5 @0x0010, then read 0x0010 on port B -> readData=0xA5A5 one cycle after the address.
REQ-034 MW=32, WSW=16: write 0x11112222 full mask, then write 0x3333FFFF mask=2'b10 to the same address -> port A read returns 0x33332222.
REQ-035 Read-during-write: @0x20 holds 0x1234; write 0x5678 while readAddr=0x20 -> readData=0x1234 next cycle, then 0x5678 on the following read.
REQ-036 LOD=1, AW=14: write 0xBEEF @0x2005 -> read @0x3005 returns 0xBEEF (alias); write 0xCAFE @0x0005 -> read @0x2005 still returns 0xBEEF.
REQ-037 LOD=0, AW=14: write distinct values @0x2005 and @0x3005 -> each reads back its own value.
REQ-038 Drive resetn=0 mid-stream -> both outputs 0 immediately; after release, earlier written data reads back intact.
